node_master: RTL

//  Master-side memory client. Drives the master port of the access mux, takes node-memory control away from the slave, and runs host commands: single read, single write, fill, dump.

---
 rtl/node_mem_pkg.sv | 26 ++
 rtl/node_master_if.sv | 36 +++
 rtl/node_master.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/node_mem_pkg.sv
// Shared types for the node-memory master client.
// Default widths, host command encodings and FSM states.
package node_mem_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NODE_W = 12;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_FILL  = 2'd2,
    OP_DUMP  = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACQUIRE,
    ST_RD_WAIT,
    ST_WR,
    ST_FILL,
    ST_DUMP_RD,
    ST_RSP,
    ST_RELEASE
  } state_e;

endpackage

// File: rtl/node_master_if.sv
// Host command/response channels of the node master.
// master = host side, slave = node_master side.
interface node_master_if
  import node_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NODE_W = DEF_NODE_W
);

  logic              cmd_valid;
  logic              cmd_ready;
  cmd_op_e           cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [NODE_W-1:0] cmd_data;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [ADDR_W-1:0] rsp_addr;
  logic [NODE_W-1:0] rsp_data;
  logic              rsp_last;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data,
    output rsp_ready,
    input  cmd_ready,
    input  rsp_valid, rsp_addr, rsp_data, rsp_last
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data,
    input  rsp_ready,
    output cmd_ready,
    output rsp_valid, rsp_addr, rsp_data, rsp_last
  );

endinterface

// File: rtl/node_master.sv
// Node-memory master: owns the access mux and runs READ/WRITE/FILL/DUMP.
// Optional NODE_MASTER_CHECKSUM_EN adds dump_csum (XOR of last DUMP beats).
module node_master
  import node_mem_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int NODE_W     = DEF_NODE_W,
  parameter int MEM_RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  node_master_if.slave      hif,
  output logic              busy,
  output logic              master_has_control,
  output logic [ADDR_W-1:0] master_read_addr,
  output logic [ADDR_W-1:0] master_write_addr,
  output logic              master_write,
  output logic [NODE_W-1:0] master_write_node,
  input  logic [NODE_W-1:0] read_node
`ifdef NODE_MASTER_CHECKSUM_EN
  ,
  output logic [NODE_W-1:0] dump_csum
`endif
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);

  state_e                state_q, state_d;
  cmd_op_e               op_q, op_d;
  logic [CNT_W-1:0]      addr_q, addr_d;
  logic [CNT_W-1:0]      addr_inc;
  logic [NODE_W-1:0]     data_q, data_d;
  logic [MEM_RD_LAT-1:0] pipe_q, pipe_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  busy_q, busy_d;
  logic                  ctrl_q, ctrl_d;
  logic [ADDR_W-1:0]     rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
  logic                  wr_q, wr_d;
  logic [NODE_W-1:0]     wr_node_q, wr_node_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [ADDR_W-1:0]     rsp_addr_q, rsp_addr_d;
  logic [NODE_W-1:0]     rsp_data_q, rsp_data_d;
  logic                  rsp_last_q, rsp_last_d;
`ifdef NODE_MASTER_CHECKSUM_EN
  logic [NODE_W-1:0]     csum_q, csum_d;
`endif

  assign addr_inc = addr_q + CNT_W'(1);

  // Next-state and next-output computation for the command FSM.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    data_d      = data_q;
    pipe_d      = pipe_q;
    cmd_ready_d = cmd_ready_q;
    busy_d      = busy_q;
    ctrl_d      = ctrl_q;
    rd_addr_d   = rd_addr_q;
    wr_addr_d   = wr_addr_q;
    wr_d        = wr_q;
    wr_node_d   = wr_node_q;
    rsp_valid_d = rsp_valid_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_data_d  = rsp_data_q;
    rsp_last_d  = rsp_last_q;
`ifdef NODE_MASTER_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        cmd_ready_d = 1'b1;
        if (hif.cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          ctrl_d      = 1'b1;
          op_d        = hif.cmd_op;
          addr_d      = {1'b0, hif.cmd_addr};
          data_d      = hif.cmd_data;
          state_d     = ST_ACQUIRE;
`ifdef NODE_MASTER_CHECKSUM_EN
          if (hif.cmd_op == OP_DUMP) csum_d = '0;
`endif
        end
      end
      ST_ACQUIRE: begin
        unique case (op_q)
          OP_READ: begin
            rd_addr_d = addr_q[ADDR_W-1:0];
            pipe_d    = '0;
            state_d   = ST_RD_WAIT;
          end
          OP_DUMP: begin
            rd_addr_d = addr_q[ADDR_W-1:0];
            pipe_d    = '0;
            state_d   = ST_DUMP_RD;
          end
          OP_WRITE: begin
            wr_d      = 1'b1;
            wr_addr_d = addr_q[ADDR_W-1:0];
            wr_node_d = data_q;
            state_d   = ST_WR;
          end
          OP_FILL: begin
            addr_d    = '0;
            wr_d      = 1'b1;
            wr_addr_d = '0;
            wr_node_d = data_q;
            state_d   = ST_FILL;
          end
        endcase
      end
      ST_RD_WAIT, ST_DUMP_RD: begin
        pipe_d = (pipe_q << 1) | MEM_RD_LAT'(1);
        if (pipe_q[MEM_RD_LAT-1]) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = read_node;
          rsp_addr_d  = addr_q[ADDR_W-1:0];
          rsp_last_d  = (op_q != OP_DUMP) || (addr_q == LAST);
          state_d     = ST_RSP;
        end
      end
      ST_WR: begin
        if (wr_q) begin
          wr_d = 1'b0;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = data_q;
          rsp_addr_d  = addr_q[ADDR_W-1:0];
          rsp_last_d  = 1'b1;
          state_d     = ST_RSP;
        end
      end
      ST_FILL: begin
        if (wr_q) begin
          addr_d = addr_inc;
          if (addr_q == LAST) wr_d = 1'b0;
          else wr_addr_d = addr_inc[ADDR_W-1:0];
        end else begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = data_q;
          rsp_addr_d  = LAST_A;
          rsp_last_d  = 1'b1;
          state_d     = ST_RSP;
        end
      end
      ST_RSP: begin
        if (hif.rsp_ready) begin
          rsp_valid_d = 1'b0;
`ifdef NODE_MASTER_CHECKSUM_EN
          if (op_q == OP_DUMP) csum_d = csum_q ^ rsp_data_q;
`endif
          if (op_q == OP_DUMP && !rsp_last_q) begin
            addr_d    = addr_inc;
            rd_addr_d = addr_inc[ADDR_W-1:0];
            pipe_d    = '0;
            state_d   = ST_DUMP_RD;
          end else begin
            state_d = ST_RELEASE;
          end
        end
      end
      ST_RELEASE: begin
        ctrl_d      = 1'b0;
        busy_d      = 1'b0;
        cmd_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any command.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_READ;
      addr_q      <= '0;
      data_q      <= '0;
      pipe_q      <= '0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      ctrl_q      <= 1'b0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      wr_q        <= 1'b0;
      wr_node_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
`ifdef NODE_MASTER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      pipe_q      <= pipe_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      ctrl_q      <= ctrl_d;
      rd_addr_q   <= rd_addr_d;
      wr_addr_q   <= wr_addr_d;
      wr_q        <= wr_d;
      wr_node_q   <= wr_node_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
`ifdef NODE_MASTER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign hif.cmd_ready      = cmd_ready_q;
  assign hif.rsp_valid      = rsp_valid_q;
  assign hif.rsp_addr       = rsp_addr_q;
  assign hif.rsp_data       = rsp_data_q;
  assign hif.rsp_last       = rsp_last_q;
  assign busy               = busy_q;
  assign master_has_control = ctrl_q;
  assign master_read_addr   = rd_addr_q;
  assign master_write_addr  = wr_addr_q;
  assign master_write       = wr_q;
  assign master_write_node  = wr_node_q;
`ifdef NODE_MASTER_CHECKSUM_EN
  assign dump_csum          = csum_q;
`endif

endmodule
